// File: rtl/switch_conditioner.sv
// Debounces one raw switch input into a clean level plus single-cycle rise/fall strobes.
// Optional auto-repeat strobe while held high: define SWITCH_CONDITIONER_REPEAT_EN.
module switch_conditioner #(
    parameter int STABLE_CYCLES = 500_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic CLK50M,
    input  logic rst_n,
    input  logic A_noisy,
    output logic A,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic rpt_pulse
);
    localparam int MAX_AB = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W  = $clog2(MAX_C) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {LOW, TO_HIGH, HIGH, TO_LOW} state_t;

    logic             r_s1, r_s2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_a, r_rise, r_fall;
    logic             w_rise_nxt, w_fall_nxt, w_a_nxt;

    always_ff @(posedge CLK50M) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= A_noisy;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            LOW: begin
                if (r_s2) begin
                    w_state_nxt = TO_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            TO_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = TO_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            TO_LOW: begin
                if (r_s2) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = '0;
            end
        endcase
        w_a_nxt = (w_state_nxt == HIGH) || (w_state_nxt == TO_LOW);
    end

    // Outputs are registered from the next-state decode so A and its strobe change together.
    always_ff @(posedge CLK50M) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign A          = r_a;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

`ifdef SWITCH_CONDITIONER_REPEAT_EN
    logic [CNT_W-1:0] r_rcnt, w_rcnt_inc, w_rtgt;
    logic             r_rarmed, r_rpt;
    logic             w_rstay, w_rfire;

    // First strobe after REPEAT_DELAY-1 counts, then rcnt restarts per REPEAT_PERIOD.
    always_comb begin
        w_rstay    = (r_state == HIGH) && r_s2;
        w_rcnt_inc = r_rcnt + 1'b1;
        w_rtgt     = r_rarmed ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY - 1);
        w_rfire    = w_rstay && (w_rcnt_inc == w_rtgt);
    end

    always_ff @(posedge CLK50M) begin
        if (!rst_n) begin
            r_rcnt   <= '0;
            r_rarmed <= 1'b0;
            r_rpt    <= 1'b0;
        end else begin
            if (w_rstay) begin
                if (w_rfire) begin
                    r_rcnt   <= '0;
                    r_rarmed <= 1'b1;
                end else begin
                    r_rcnt <= w_rcnt_inc;
                end
            end else begin
                r_rcnt   <= '0;
                r_rarmed <= 1'b0;
            end
            r_rpt <= w_rfire;
        end
    end

    assign rpt_pulse = r_rpt;
`else
    assign rpt_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Randomized + directed bench for switch_conditioner against a run-length debounce model.
module tb_switch_conditioner;
    localparam int SC = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic CLK50M = 1'b0;
    logic rst_n  = 1'b0;
    logic A_noisy = 1'b0;
    logic A, rise_pulse, fall_pulse, rpt_pulse;

    int n_vec = 0;
    int n_err = 0;

    // Model: two-sample delay line, then A flips once SC+1 consecutive delayed samples disagree.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_a = 1'b0;
    logic m_rise = 1'b0, m_fall = 1'b0, m_rpt = 1'b0;
    int   run = 0;
    int   hc  = 0;

    switch_conditioner #(
        .STABLE_CYCLES(SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CLK50M    (CLK50M),
        .rst_n     (rst_n),
        .A_noisy   (A_noisy),
        .A         (A),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .rpt_pulse (rpt_pulse)
    );

    always #5 CLK50M = ~CLK50M;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic s2o;
        logic d;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_rpt  = 1'b0;
        if (!rst_n) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_a  = 1'b0;
            run  = 0;
            hc   = 0;
        end else begin
            s2o  = m_s2;
            m_s2 = m_s1;
            m_s1 = A_noisy;
            d    = (s2o != m_a);
            if (d) begin
                run++;
                hc = 0;
                if (run == SC + 1) begin
                    m_a = ~m_a;
                    if (m_a) m_rise = 1'b1;
                    else     m_fall = 1'b1;
                    run = 0;
                end
            end else begin
                if (m_a) begin
                    if (run == 0) begin
                        hc++;
`ifdef SWITCH_CONDITIONER_REPEAT_EN
                        if (hc == RD - 1 || (hc > RD - 1 && (hc - (RD - 1)) % RP == 0))
                            m_rpt = 1'b1;
`endif
                    end else begin
                        hc = 0;
                    end
                end
                run = 0;
            end
        end
    endtask

    task automatic step(input logic rn, input logic a);
        rst_n   = rn;
        A_noisy = a;
        @(posedge CLK50M);
        model_edge();
        @(negedge CLK50M);
        chk("A", A, m_a);
        chk("rise_pulse", rise_pulse, m_rise);
        chk("fall_pulse", fall_pulse, m_fall);
        chk("rpt_pulse", rpt_pulse, m_rpt);
        chk("rise_fall_excl", rise_pulse & fall_pulse, 1'b0);
    endtask

    task automatic hold(input int n, input logic a);
        for (int i = 0; i < n; i++) step(1'b1, a);
    endtask

    initial begin
        @(negedge CLK50M);
        // Reset with input high, then release
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        hold(14, 1'b1);
        hold(14, 1'b0);
        // Clean press and release
        hold(30, 1'b1);
        hold(14, 1'b0);
        // Bounce bursts then steady high
        for (int k = 0; k < 4; k++) begin
            hold(5, 1'b1);
            hold(1, 1'b0);
        end
        hold(14, 1'b1);
        hold(14, 1'b0);
        // Glitches of several widths around the threshold
        for (int w = 7; w <= 10; w++) begin
            hold(w, 1'b1);
            hold(14, 1'b0);
        end
        // Reset mid-debounce, then clean restart
        hold(8, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
        hold(14, 1'b1);
        hold(14, 1'b0);
        // Long hold for auto-repeat, short low blip while held, then release
        hold(60, 1'b1);
        hold(3, 1'b0);
        hold(40, 1'b1);
        hold(20, 1'b0);
        // Reset mid-HIGH
        hold(20, 1'b1);
        step(1'b0, 1'b1);
        hold(14, 1'b0);
        // Random segments
        for (int s = 0; s < 400; s++) begin
            int   len;
            logic val;
            logic rn;
            rn  = ($urandom_range(0, 39) != 0);
            val = 1'($urandom_range(0, 1));
            if (!rn)                             len = $urandom_range(1, 3);
            else if ($urandom_range(0, 9) == 0)  len = $urandom_range(30, 60);
            else                                 len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) step(rn, val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
